// File: rtl/modinv_helper_pkg.sv
// Shared encodings and helpers for the modular-invertor word mover.
// Mode and FSM state encodings plus the width helper used for counters.
package modinv_helper_pkg;

   typedef enum logic [1:0] {
      MODE_COPY  = 2'b00,
      MODE_CLEAR = 2'b01,
      MODE_SHR1  = 2'b10,
      MODE_SHL1  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bits needed to hold values 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/modinv_helper_move_rdpipe.sv
// Read-latency pipe: carries {valid, destination word index} from read issue
// to the cycle the source data arrives, so it directly frames each write.
module modinv_helper_rdpipe
   import modinv_helper_pkg::*;
#(
   parameter int LAT   = 1,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_vld,
   output logic [IDX_W-1:0] out_idx
);

   logic [LAT-1:0]            vld_q, vld_d;
   logic [LAT-1:0][IDX_W-1:0] idx_q, idx_d;

   // Index is zeroed when invalid so the shared address bus idles at 0.
   always_comb begin
      vld_d    = vld_q;
      idx_d    = idx_q;
      vld_d[0] = in_vld;
      idx_d[0] = in_vld ? in_idx : '0;
      for (int s = 1; s < LAT; s++) begin
         vld_d[s] = vld_q[s-1];
         idx_d[s] = idx_q[s-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         idx_q <= '0;
      end else begin
         vld_q <= vld_d;
         idx_q <= idx_d;
      end
   end

   assign out_vld = vld_q[LAT-1];
   assign out_idx = idx_q[LAT-1];

endmodule

// File: rtl/modinv_helper_move.sv
// Word mover: streams an operand from the source buffer into the selected
// destination banks as a copy, clear, or one-bit logical shift.
module modinv_helper_move
   import modinv_helper_pkg::*;
#(
   parameter int OPERAND_NUM_WORDS = 8,
   parameter int OPERAND_ADDR_BITS = 3,
   parameter int BUFFER_NUM_WORDS  = 9,
   parameter int BUFFER_ADDR_BITS  = 4,
   parameter int READ_LATENCY      = 1,
   parameter int NUM_DST           = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ena,
   input  logic [1:0]                   mode,
   input  logic [NUM_DST-1:0]           dst_mask,
   output logic                         rdy,
   output logic                         done,
   output logic [BUFFER_ADDR_BITS-1:0]  s_addr,
   input  logic [31:0]                  s_din,
   output logic [OPERAND_ADDR_BITS-1:0] d_addr,
   output logic [NUM_DST-1:0]           d_wren,
   output logic [31:0]                  d_dout
);

   localparam int CNT_W     = clog2(OPERAND_NUM_WORDS + 2);
   localparam int SHR_READS = (BUFFER_NUM_WORDS < OPERAND_NUM_WORDS + 1) ?
                              BUFFER_NUM_WORDS : OPERAND_NUM_WORDS + 1;
   localparam logic [CNT_W-1:0]             N_LIM    = CNT_W'(OPERAND_NUM_WORDS);
   localparam logic [CNT_W-1:0]             SHR_LIM  = CNT_W'(SHR_READS);
   localparam logic [OPERAND_ADDR_BITS-1:0] LAST_IDX = OPERAND_ADDR_BITS'(OPERAND_NUM_WORDS - 1);

   state_e                 state_q, state_d;
   mode_e                  mode_q, mode_d;
   logic [NUM_DST-1:0]     mask_q, mask_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   carry_q, carry_d;
   logic [31:1]            prev_q, prev_d;

   logic                         iss;
   logic [CNT_W-1:0]             lim;
   logic                         pipe_in_vld, pipe_out_vld;
   logic [OPERAND_ADDR_BITS-1:0] pipe_in_idx, pipe_out_idx;
   logic                         wr;
   logic [OPERAND_ADDR_BITS-1:0] wr_idx;

   modinv_helper_rdpipe #(
      .LAT   (READ_LATENCY),
      .IDX_W (OPERAND_ADDR_BITS)
   ) u_rdpipe (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (pipe_in_vld),
      .in_idx  (pipe_in_idx),
      .out_vld (pipe_out_vld),
      .out_idx (pipe_out_idx)
   );

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      prev_d      = prev_q;
      pipe_in_vld = 1'b0;
      pipe_in_idx = '0;
      wr          = 1'b0;
      wr_idx      = '0;
      s_addr      = '0;
      d_dout      = '0;

      // Clear issues N write slots; the others issue one slot per source read.
      lim = (mode_q == MODE_SHR1) ? SHR_LIM : N_LIM;
      iss = (state_q == ST_RUN) && (cnt_q < lim);
      if (iss) cnt_d = cnt_q + 1'b1;

      // shr1 read j produces word j-1, so its first read writes nothing.
      if (iss && mode_q != MODE_CLEAR) begin
         s_addr = BUFFER_ADDR_BITS'(cnt_q);
         if (mode_q == MODE_SHR1) begin
            pipe_in_vld = (cnt_q != '0);
            pipe_in_idx = OPERAND_ADDR_BITS'(cnt_q - 1'b1);
         end else begin
            pipe_in_vld = 1'b1;
            pipe_in_idx = OPERAND_ADDR_BITS'(cnt_q);
         end
      end

      if (state_q == ST_RUN) begin
         prev_d = s_din[31:1];
         if (mode_q == MODE_CLEAR) begin
            wr     = iss;
            wr_idx = iss ? OPERAND_ADDR_BITS'(cnt_q) : '0;
         end else begin
            wr     = pipe_out_vld;
            wr_idx = pipe_out_idx;
         end
      end

      if (wr) begin
         case (mode_q)
            MODE_COPY:  d_dout = s_din;
            MODE_CLEAR: d_dout = '0;
            MODE_SHL1:  d_dout = {s_din[30:0], carry_q};
            default:    d_dout = {s_din[0], prev_q[31:1]};
         endcase
         if (mode_q == MODE_SHL1) carry_d = s_din[31];
      end

      case (state_q)
         ST_IDLE: begin
            if (ena) begin
               state_d = ST_RUN;
               mode_d  = mode_e'(mode);
               mask_d  = dst_mask;
               cnt_d   = '0;
               carry_d = 1'b0;
               prev_d  = '0;
            end
         end
         ST_RUN: begin
            if (wr && wr_idx == LAST_IDX) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_COPY;
         mask_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         prev_q  <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         prev_q  <= prev_d;
      end
   end

   assign rdy    = (state_q == ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign d_addr = wr_idx;
   assign d_wren = wr ? mask_q : '0;

endmodule

// File: tb/tb_modinv_helper_move.sv
// Bench for modinv_helper_move: three geometries (N/L = 8/1, 4/2, 1/3) run
// directed and random operations against a per-cycle model of the op rules.
module tb_modinv_helper_move;
   import modinv_helper_pkg::*;

   localparam int L0 = 1;
   localparam int L1 = 2;
   localparam int L2 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  ena;
   logic [1:0]  mode;
   logic [1:0]  mask;
   logic [31:0] src [16];

   int n_cmp = 0;
   int n_err = 0;
   int op_id = 0;

   logic        rdy0, done0, rdy1, done1, rdy2, done2;
   logic [3:0]  sa0;
   logic [2:0]  sa1;
   logic [0:0]  sa2;
   logic [2:0]  da0;
   logic [1:0]  da1;
   logic [0:0]  da2;
   logic [1:0]  wr0, wr1, wr2;
   logic [31:0] dd0, dd1, dd2, sd0, sd1, sd2;
   logic [3:0]  dl0 [L0];
   logic [2:0]  dl1 [L1];
   logic [0:0]  dl2 [L2];

   // Source RAM models: address delayed L cycles, then looked up.
   always @(posedge clk) begin
      dl0[0] <= sa0;
      for (int i = 1; i < L0; i++) dl0[i] <= dl0[i-1];
   end
   always @(posedge clk) begin
      dl1[0] <= sa1;
      for (int i = 1; i < L1; i++) dl1[i] <= dl1[i-1];
   end
   always @(posedge clk) begin
      dl2[0] <= sa2;
      for (int i = 1; i < L2; i++) dl2[i] <= dl2[i-1];
   end
   assign sd0 = src[int'(dl0[L0-1])];
   assign sd1 = src[int'(dl1[L1-1])];
   assign sd2 = src[int'(dl2[L2-1])];

   modinv_helper_move #(.OPERAND_NUM_WORDS(8), .OPERAND_ADDR_BITS(3), .BUFFER_NUM_WORDS(9),
      .BUFFER_ADDR_BITS(4), .READ_LATENCY(L0), .NUM_DST(2)) u0 (
      .clk(clk), .rst(rst), .ena(ena[0]), .mode(mode), .dst_mask(mask), .rdy(rdy0), .done(done0),
      .s_addr(sa0), .s_din(sd0), .d_addr(da0), .d_wren(wr0), .d_dout(dd0));

   modinv_helper_move #(.OPERAND_NUM_WORDS(4), .OPERAND_ADDR_BITS(2), .BUFFER_NUM_WORDS(5),
      .BUFFER_ADDR_BITS(3), .READ_LATENCY(L1), .NUM_DST(2)) u1 (
      .clk(clk), .rst(rst), .ena(ena[1]), .mode(mode), .dst_mask(mask), .rdy(rdy1), .done(done1),
      .s_addr(sa1), .s_din(sd1), .d_addr(da1), .d_wren(wr1), .d_dout(dd1));

   modinv_helper_move #(.OPERAND_NUM_WORDS(1), .OPERAND_ADDR_BITS(1), .BUFFER_NUM_WORDS(2),
      .BUFFER_ADDR_BITS(1), .READ_LATENCY(L2), .NUM_DST(2)) u2 (
      .clk(clk), .rst(rst), .ena(ena[2]), .mode(mode), .dst_mask(mask), .rdy(rdy2), .done(done2),
      .s_addr(sa2), .s_din(sd2), .d_addr(da2), .d_wren(wr2), .d_dout(dd2));

   logic [31:0] o_rdy, o_done, o_sa, o_da, o_wr, o_dd;

   function automatic int n_of(input int sel);
      return (sel == 0) ? 8 : (sel == 1) ? 4 : 1;
   endfunction

   function automatic int l_of(input int sel);
      return (sel == 0) ? L0 : (sel == 1) ? L1 : L2;
   endfunction

   task automatic sample(input int sel);
      case (sel)
         0: begin
            o_rdy = 32'(rdy0); o_done = 32'(done0); o_sa = 32'(sa0);
            o_da = 32'(da0); o_wr = 32'(wr0); o_dd = dd0;
         end
         1: begin
            o_rdy = 32'(rdy1); o_done = 32'(done1); o_sa = 32'(sa1);
            o_da = 32'(da1); o_wr = 32'(wr1); o_dd = dd1;
         end
         default: begin
            o_rdy = 32'(rdy2); o_done = 32'(done2); o_sa = 32'(sa2);
            o_da = 32'(da2); o_wr = 32'(wr2); o_dd = dd2;
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fill_src(input int n);
      for (int i = 0; i <= n; i++) src[i] = $urandom;
   endtask

   // Called at a negedge with the selected DUT idle; runs one op and checks
   // every cycle. With hold=1, ena stays high so the next op starts at once.
   task automatic run_op(input int sel, input logic [1:0] md, input logic [1:0] mk, input bit hold);
      int n, l, r, ws, last, wi;
      logic [31:0] expw [8];
      bit writing;
      op_id++;
      n = n_of(sel);
      l = l_of(sel);
      r = (md == MODE_CLEAR) ? 0 : (md == MODE_SHR1) ? n + 1 : n;
      ws = (md == MODE_CLEAR) ? 1 : (md == MODE_SHR1) ? 2 + l : 1 + l;
      last = ws + n;
      for (int i = 0; i < n; i++) begin
         case (md)
            MODE_COPY:  expw[i] = src[i];
            MODE_CLEAR: expw[i] = 32'd0;
            MODE_SHL1:  expw[i] = (src[i] << 1) | ((i > 0) ? (src[i-1] >> 31) : 32'd0);
            default:    expw[i] = (src[i] >> 1) | ((src[i+1] & 32'd1) << 31);
         endcase
      end
      sample(sel);
      chk($sformatf("op%0d rdy_start", op_id), o_rdy, 32'd1);
      mode = md;
      mask = mk;
      ena[sel] = 1'b1;
      for (int k = 1; k <= last + 1; k++) begin
         @(negedge clk);
         if (!hold) ena[sel] = 1'b0;
         sample(sel);
         wi = k - ws;
         writing = (wi >= 0) && (wi < n);
         chk($sformatf("op%0d k%0d rdy", op_id, k), o_rdy, (k == last + 1) ? 32'd1 : 32'd0);
         chk($sformatf("op%0d k%0d done", op_id, k), o_done, (k == last) ? 32'd1 : 32'd0);
         chk($sformatf("op%0d k%0d wren", op_id, k), o_wr, writing ? 32'(mk) : 32'd0);
         chk($sformatf("op%0d k%0d dout", op_id, k), o_dd, writing ? expw[wi] : 32'd0);
         if (writing) chk($sformatf("op%0d k%0d daddr", op_id, k), o_da, 32'(wi));
         if (k <= r) chk($sformatf("op%0d k%0d saddr", op_id, k), o_sa, 32'(k - 1));
         if (md == MODE_CLEAR) chk($sformatf("op%0d k%0d saddr_clr", op_id, k), o_sa, 32'd0);
      end
      if (!hold) begin
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sample(sel);
            chk($sformatf("op%0d idle%0d rdy", op_id, k), o_rdy, 32'd1);
            chk($sformatf("op%0d idle%0d done", op_id, k), o_done, 32'd0);
            chk($sformatf("op%0d idle%0d wren", op_id, k), o_wr, 32'd0);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      ena  = '0;
      mode = 2'b00;
      mask = 2'b00;
      for (int i = 0; i < 16; i++) src[i] = 32'd0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sample(s);
         chk($sformatf("rst%0d rdy", s), o_rdy, 32'd1);
         chk($sformatf("rst%0d done", s), o_done, 32'd0);
         chk($sformatf("rst%0d wren", s), o_wr, 32'd0);
         chk($sformatf("rst%0d dout", s), o_dd, 32'd0);
         chk($sformatf("rst%0d saddr", s), o_sa, 32'd0);
         chk($sformatf("rst%0d daddr", s), o_da, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Copy with stepped pattern, only bank 0 enabled.
      for (int i = 0; i <= 8; i++) src[i] = 32'h11111111 * 32'(i + 1);
      run_op(0, MODE_COPY, 2'b01, 1'b0);

      // shr1 on all-ones-in-LSB source: every word becomes 0x80000000.
      for (int i = 0; i <= 4; i++) src[i] = 32'h00000001;
      run_op(1, MODE_SHR1, 2'b11, 1'b0);

      // shl1 carry chain across words.
      src[0] = 32'h80000000; src[1] = 32'h0; src[2] = 32'h80000001; src[3] = 32'hFFFFFFFF;
      run_op(1, MODE_SHL1, 2'b10, 1'b0);

      // Clear to both banks.
      run_op(0, MODE_CLEAR, 2'b11, 1'b0);

      // ena held through a copy; next op (no destinations) starts on rdy.
      fill_src(8);
      run_op(0, MODE_COPY, 2'b11, 1'b1);
      run_op(0, MODE_SHR1, 2'b00, 1'b0);

      // Abort a copy with reset in cycle 5.
      fill_src(8);
      mode = MODE_COPY;
      mask = 2'b11;
      ena[0] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         ena[0] = 1'b0;
      end
      sample(0);
      chk("abort pre wren", o_wr, 32'd3);
      chk("abort pre dout", o_dd, src[3]);
      rst = 1'b1;
      #1;
      sample(0);
      chk("abort wren", o_wr, 32'd0);
      chk("abort rdy", o_rdy, 32'd1);
      chk("abort done", o_done, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         sample(0);
         chk($sformatf("abort post%0d done", k), o_done, 32'd0);
         chk($sformatf("abort post%0d wren", k), o_wr, 32'd0);
      end
      fill_src(8);
      run_op(0, MODE_COPY, 2'b01, 1'b0);

      // N=1 boundary in every mode.
      for (int m = 0; m < 4; m++) begin
         fill_src(1);
         run_op(2, 2'(m), 2'b11, 1'b0);
      end

      // Random operations across all geometries.
      for (int t = 0; t < 16; t++) begin
         int sel;
         sel = int'($urandom_range(0, 2));
         fill_src(n_of(sel));
         run_op(sel, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
